// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - encodes abstract MIPS instructions and streams them into instruction memory
module inst_encoder_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    op,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] baseReg;
    logic [5:0]    funct;
    logic [5:0]    opcode;
    logic          isR;
    logic          isI;
    logic          encLegal;
    logic [31:0]   encWord;
    logic          accept;

    assign in_ready = (state == LOAD) && (count < DEPTH_W);
    assign accept   = in_valid && in_ready;
    assign done     = (state == DONE);

    always_comb begin
        funct  = 6'h00;
        opcode = 6'h00;
        isR    = 1'b0;
        isI    = 1'b0;
        case (op)
            5'h01: begin isR = 1'b1; funct = 6'h20; end
            5'h02: begin isR = 1'b1; funct = 6'h21; end
            5'h03: begin isR = 1'b1; funct = 6'h22; end
            5'h04: begin isR = 1'b1; funct = 6'h23; end
            5'h05: begin isR = 1'b1; funct = 6'h24; end
            5'h06: begin isR = 1'b1; funct = 6'h25; end
            5'h07: begin isR = 1'b1; funct = 6'h26; end
            5'h08: begin isR = 1'b1; funct = 6'h27; end
            5'h09: begin isR = 1'b1; funct = 6'h2A; end
            5'h0A: begin isR = 1'b1; funct = 6'h2B; end
            5'h0B: begin isI = 1'b1; opcode = 6'h08; end
            5'h0C: begin isI = 1'b1; opcode = 6'h09; end
            5'h0D: begin isI = 1'b1; opcode = 6'h0A; end
            5'h0E: begin isI = 1'b1; opcode = 6'h0B; end
            5'h0F: begin isI = 1'b1; opcode = 6'h0C; end
            5'h10: begin isI = 1'b1; opcode = 6'h0D; end
            5'h11: begin isI = 1'b1; opcode = 6'h0E; end
            5'h12: begin isI = 1'b1; opcode = 6'h0F; end
            5'h13: begin isI = 1'b1; opcode = 6'h04; end
            5'h14: begin isI = 1'b1; opcode = 6'h05; end
            5'h15: begin isI = 1'b1; opcode = 6'h23; end
            5'h16: begin isI = 1'b1; opcode = 6'h2B; end
            default: ;
        endcase
    end

    // LUI (op 0x12) has no source register, so rs is forced to zero
    assign encLegal = isR || isI || (op == 5'h00);
    assign encWord  = isR ? {6'h00, rs, rt, rd, 5'h00, funct}
                    : isI ? {opcode, (op == 5'h12) ? 5'h00 : rs, rt, imm}
                    : 32'h0000_0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baseReg   <= '0;
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        baseReg <= base_addr;
                        count   <= '0;
                        err     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept && encLegal) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= baseReg + count[AW-1:0];
                        mem_wdata <= encWord;
                        count     <= count + (AW+1)'(1);
                    end
                    if (accept && !encLegal)
                        err <= 1'b1;
                    // leaving LOAD on the same edge as the last write keeps that pulse intact
                    if (finish || (accept && encLegal && (count + (AW+1)'(1) == DEPTH_W)))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - randomized and directed bench for inst_encoder_loader
module tb_inst_encoder_loader;

    typedef struct {
        int          phase;
        int          cnt;
        int          base;
        bit          err;
        bit          we;
        int          addr;
        logic [31:0] data;
    } mst_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  op = '0, rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic [7:0]  baseA = '0;
    logic [1:0]  baseB;

    logic        rdyA, weA, doneA, errA;
    logic [7:0]  addrA;
    logic [31:0] dataA;
    logic [8:0]  countA;
    logic        rdyB, weB, doneB, errB;
    logic [1:0]  addrB;
    logic [31:0] dataB;
    logic [2:0]  countB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    mst_t mA, mB;
    wr_t logA[$];
    wr_t logB[$];

    assign baseB = baseA[1:0];

    inst_encoder_loader dutA (
        .clk(clk), .reset(reset), .start(start), .base_addr(baseA), .finish(finish),
        .in_valid(in_valid), .in_ready(rdyA), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .mem_we(weA), .mem_addr(addrA), .mem_wdata(dataA), .count(countA), .done(doneA), .err(errA)
    );

    inst_encoder_loader #(.AW(2), .DEPTH(4)) dutB (
        .clk(clk), .reset(reset), .start(start), .base_addr(baseB), .finish(finish),
        .in_valid(in_valid), .in_ready(rdyB), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .mem_we(weB), .mem_addr(addrB), .mem_wdata(dataB), .count(countB), .done(doneB), .err(errB)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // returns {legal, word}
    function automatic logic [32:0] encode(logic [4:0] o, logic [4:0] s, logic [4:0] t,
                                           logic [4:0] d, logic [15:0] i);
        logic [5:0] functTab [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                      6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        logic [5:0] opcTab [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                    6'h0E, 6'h0F, 6'h04, 6'h05, 6'h23, 6'h2B};
        int n = int'(o);
        if (n == 0) return {1'b1, 32'h0};
        if (n >= 1 && n <= 10) return {1'b1, 6'h00, s, t, d, 5'h00, functTab[n-1]};
        if (n >= 11 && n <= 22) return {1'b1, opcTab[n-11], (n == 18) ? 5'h00 : s, t, i};
        return {1'b0, 32'h0};
    endfunction

    function automatic mst_t step(mst_t s, int aw, int depth);
        mst_t n = s;
        logic [32:0] e;
        n.we = 1'b0;
        if (s.phase == 1) begin
            if (in_valid && s.cnt < depth) begin
                e = encode(op, rs, rt, rd, imm);
                if (e[32]) begin
                    n.we   = 1'b1;
                    n.addr = (s.base + s.cnt) % (1 << aw);
                    n.data = e[31:0];
                    n.cnt  = s.cnt + 1;
                end else begin
                    n.err = 1'b1;
                end
            end
            if (finish || n.cnt == depth) n.phase = 2;
        end else if (start) begin
            n.phase = 1;
            n.base  = int'(baseA) % (1 << aw);
            n.cnt   = 0;
            n.err   = 1'b0;
        end
        return n;
    endfunction

    initial begin
        mA = '{default: 0};
        mB = '{default: 0};
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mA <= '{default: 0};
            mB <= '{default: 0};
        end else begin
            mA <= step(mA, 8, 256);
            mB <= step(mB, 2, 4);
        end
    end

    always @(negedge clk) begin
        chk("A.in_ready", 32'(rdyA), 32'(mA.phase == 1 && mA.cnt < 256));
        chk("A.done", 32'(doneA), 32'(mA.phase == 2));
        chk("A.count", 32'(countA), 32'(mA.cnt));
        chk("A.err", 32'(errA), 32'(mA.err));
        chk("A.mem_we", 32'(weA), 32'(mA.we));
        if (mA.we) begin
            chk("A.mem_addr", 32'(addrA), 32'(mA.addr));
            chk("A.mem_wdata", dataA, mA.data);
        end
        chk("B.in_ready", 32'(rdyB), 32'(mB.phase == 1 && mB.cnt < 4));
        chk("B.done", 32'(doneB), 32'(mB.phase == 2));
        chk("B.count", 32'(countB), 32'(mB.cnt));
        chk("B.err", 32'(errB), 32'(mB.err));
        chk("B.mem_we", 32'(weB), 32'(mB.we));
        if (mB.we) begin
            chk("B.mem_addr", 32'(addrB), 32'(mB.addr));
            chk("B.mem_wdata", dataB, mB.data);
        end
        if (weA === 1'b1) logA.push_back('{int'(addrA), dataA, cyc});
        if (weB === 1'b1) logB.push_back('{int'(addrB), dataB, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    endtask

    task automatic give(logic [4:0] o, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                        logic [15:0] i, logic f);
        start = 1'b0; in_valid = 1'b1; op = o; rs = s; rt = t; rd = d; imm = i; finish = f;
        tick();
    endtask

    task automatic sess(logic [7:0] b);
        idle();
        start = 1'b1; baseA = b;
        tick();
        start = 1'b0;
    endtask

    task automatic chkLog(string name, int idx, int expAddr, logic [31:0] expData);
        if (idx < logA.size()) begin
            chk({name, ".addr"}, 32'(logA[idx].addr), 32'(expAddr));
            chk({name, ".data"}, logA[idx].data, expData);
        end else begin
            chk({name, ".present"}, 32'(0), 32'(1));
        end
    endtask

    initial begin
        int n0;
        int nb;
        logic [31:0] expD [6] = '{32'h2008FFFF, 32'h8FA40004, 32'h1022FFFE,
                                  32'h3C051234, 32'h0, 32'h0};
        int expB [4] = '{3, 0, 1, 2};
        logic [32:0] e;

        e = encode(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        chk("model.add", e[31:0], 32'h00221820);
        e = encode(5'h12, 5'd7, 5'd5, 5'd0, 16'h1234);
        chk("model.lui", e[31:0], 32'h3C051234);

        tick(); tick();
        chk("rst.we", 32'(weA), 32'h0);
        chk("rst.addr", 32'(addrA), 32'h0);
        chk("rst.wdata", dataA, 32'h0);
        chk("rst.count", 32'(countA), 32'h0);
        chk("rst.ready", 32'(rdyA), 32'h0);
        chk("rst.done", 32'(doneA), 32'h0);
        reset = 1'b0;
        tick();

        n0 = logA.size();
        sess(8'h10);
        give(5'h01, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        idle();
        chk("t1.done", 32'(doneA), 32'h1);
        chk("t1.count", 32'(countA), 32'h1);
        tick(); tick();
        chk("t1.nwr", 32'(logA.size() - n0), 32'h1);
        chkLog("t1.w0", n0, 'h10, 32'h00221820);

        n0 = logA.size();
        sess(8'h20);
        give(5'h0B, 5'd0, 5'd8, 5'd0, 16'hFFFF, 1'b0);
        give(5'h15, 5'd29, 5'd4, 5'd0, 16'h0004, 1'b0);
        give(5'h13, 5'd1, 5'd2, 5'd0, 16'hFFFE, 1'b0);
        give(5'h12, 5'd7, 5'd5, 5'd0, 16'h1234, 1'b0);
        give(5'h00, 5'd3, 5'd3, 5'd3, 16'h3333, 1'b1);
        idle();
        tick(); tick();
        chk("t2.nwr", 32'(logA.size() - n0), 32'h5);
        for (int k = 0; k < 5; k++) chkLog("t2.w", n0 + k, 'h20 + k, expD[k]);
        if (logA.size() >= n0 + 4)
            for (int k = 0; k < 3; k++)
                chk("t2.b2b", 32'(logA[n0+k+1].cyc - logA[n0+k].cyc), 32'h1);

        n0 = logA.size();
        sess(8'h40);
        give(5'h00, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0);
        give(5'h1F, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0);
        chk("t3.errNext", 32'(errA), 32'h1);
        give(5'h00, 5'd1, 5'd1, 5'd1, 16'h1, 1'b1);
        idle();
        tick(); tick();
        chk("t3.err", 32'(errA), 32'h1);
        chk("t3.count", 32'(countA), 32'h2);
        chk("t3.nwr", 32'(logA.size() - n0), 32'h2);
        chkLog("t3.w0", n0, 'h40, 32'h0);
        chkLog("t3.w1", n0 + 1, 'h41, 32'h0);

        nb = logB.size();
        sess(8'h03);
        for (int k = 0; k < 5; k++) begin
            give(5'h02, 5'(k), 5'd2, 5'd3, 16'h0, 1'b0);
            if (k == 3) chk("t4.readyLow", 32'(rdyB), 32'h0);
        end
        idle();
        tick(); tick();
        chk("t4.doneB", 32'(doneB), 32'h1);
        chk("t4.countB", 32'(countB), 32'h4);
        chk("t4.nwrB", 32'(logB.size() - nb), 32'h4);
        if (logB.size() >= nb + 4)
            for (int k = 0; k < 4; k++) chk("t4.addrB", 32'(logB[nb+k].addr), 32'(expB[k]));
        finish = 1'b1;
        tick();
        idle();

        sess(8'h50);
        n0 = logA.size();
        nb = logB.size();
        in_valid = 1'b1; op = 5'h01; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        #2 reset = 1'b1;
        tick();
        idle();
        chk("t5.we", 32'(weA), 32'h0);
        chk("t5.count", 32'(countA), 32'h0);
        chk("t5.addr", 32'(addrA), 32'h0);
        chk("t5.wdata", dataA, 32'h0);
        chk("t5.err", 32'(errA), 32'h0);
        reset = 1'b0;
        tick(); tick();
        chk("t5.nowrA", 32'(logA.size() - n0), 32'h0);
        chk("t5.nowrB", 32'(logB.size() - nb), 32'h0);
        sess(8'h60);
        chk("t5.freshCount", 32'(countA), 32'h0);
        give(5'h01, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        idle();
        tick(); tick();
        chkLog("t5.w0", n0, 'h60, 32'h00221820);

        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom_range(0, 19) == 0);
            finish   = ($urandom_range(0, 14) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            op  = 5'($urandom_range(0, 31));
            rs  = 5'($urandom);
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            imm = 16'($urandom);
            baseA = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
